pipeline_hazard_ctrl: RTL and testbench

Pipeline control block for the 5-stage ARM core: the producer side of the freeze/flush controls consumed by the PC, IF/ID and ID/EX pipeline registers. Each cycle it evaluates data hazards between the instruction in ID and the instructions in EXE/MEM, branch redirection from EXE, and multi-cycle data-memory waits. From these it drives the stall, bubble and flush controls. It also keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/branch/memory-wait controller for the 5-stage ARM core pipeline.
// Drives the freeze/flush controls and keeps saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter bit FORWARD_EN  = 1'b0,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             exe_branch,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_front,
    output logic             freeze_idex,
    output logic             freeze_back,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [WC_W-1:0] TO_LAST = WC_W'(MEM_TIMEOUT - 1);
    // A timeout of 0 or 1 cycles is reached by the very first wait cycle.
    localparam bit TO_IMMEDIATE = (MEM_TIMEOUT <= 1);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            to_set;
    logic            m1, m2, n1, n2, hazard, memwait;
    logic            sel_mw, sel_br, sel_hz;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [WC_W-1:0] sat_wc(input logic [WC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign m1 = id_use_src1 & exe_wb_en & (id_src1 == exe_dest);
    assign m2 = id_two_src  & exe_wb_en & (id_src2 == exe_dest);
    assign n1 = id_use_src1 & mem_wb_en & (id_src1 == mem_dest);
    assign n2 = id_two_src  & mem_wb_en & (id_src2 == mem_dest);

    assign hazard  = FORWARD_EN ? (exe_mem_r_en & (m1 | m2)) : (m1 | m2 | n1 | n2);
    assign memwait = mem_req & ~mem_ready;

    // Priority: memory wait, then branch redirect, then data hazard.
    assign sel_mw = memwait;
    assign sel_br = ~memwait & exe_branch;
    assign sel_hz = ~memwait & ~exe_branch & hazard;

    always_comb begin
        freeze_front = 1'b0;
        freeze_idex  = 1'b0;
        freeze_back  = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        if (!rst) begin
            freeze_front = sel_mw | sel_hz;
            freeze_idex  = sel_mw;
            freeze_back  = sel_mw;
            flush_ifid   = sel_br;
            flush_idex   = sel_br | sel_hz;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        to_set       = 1'b0;
        case (state)
            ST_RUN: begin
                if (memwait) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                    to_set       = TO_IMMEDIATE;
                end
            end
            ST_WAIT: begin
                // A dropped request without ready is abandoned, not timed out.
                if (!mem_req || mem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = sat_wc(wait_cnt);
                    to_set       = (wait_cnt >= TO_LAST);
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            hazard_cnt  <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (to_set) mem_timeout <= 1'b1;
            if (sel_hz) hazard_cnt  <= sat_cnt(hazard_cnt);
            if (sel_br) flush_cnt   <= sat_cnt(flush_cnt);
            if (sel_mw) memwait_cnt <= sat_cnt(memwait_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: one instance without forwarding,
// one with forwarding, both with a 4-cycle memory timeout and shared inputs.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       exe_branch, mem_req, mem_ready;

    logic        ff0, fi0, fb0, fif0, fid0, to0;
    logic        ff1, fi1, fb1, fif1, fid1, to1;
    logic [15:0] hc0, fc0, mc0, hc1, fc1, mc1;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [4:0] c0;
        logic [4:0] c1;
    } exp_t;
    exp_t sbq[$];

    int m_hz[2], m_fl[2], m_mw[2], m_wc[2];
    bit m_st[2], m_to[2];
    int snap;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .exe_branch(exe_branch), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze_front(ff0), .freeze_idex(fi0),
        .freeze_back(fb0), .flush_ifid(fif0), .flush_idex(fid0),
        .mem_timeout(to0), .hazard_cnt(hc0), .flush_cnt(fc0), .memwait_cnt(mc0)
    );

    pipeline_hazard_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .exe_branch(exe_branch), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze_front(ff1), .freeze_idex(fi1),
        .freeze_back(fb1), .flush_ifid(fif1), .flush_idex(fid1),
        .mem_timeout(to1), .hazard_cnt(hc1), .flush_cnt(fc1), .memwait_cnt(mc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Expected {freeze_front, freeze_idex, freeze_back, flush_ifid, flush_idex}.
    function automatic logic [4:0] ctrl_model(input bit fe);
        bit e1, e2, n1, n2, hz;
        e1 = id_use_src1 && exe_wb_en && (id_src1 == exe_dest);
        e2 = id_two_src  && exe_wb_en && (id_src2 == exe_dest);
        n1 = id_use_src1 && mem_wb_en && (id_src1 == mem_dest);
        n2 = id_two_src  && mem_wb_en && (id_src2 == mem_dest);
        hz = fe ? (exe_mem_r_en && (e1 || e2)) : (e1 || e2 || n1 || n2);
        if (rst)                       return 5'b00000;
        if (mem_req && !mem_ready)     return 5'b11100;
        if (exe_branch)                return 5'b00011;
        if (hz)                        return 5'b10001;
        return 5'b00000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hz[i] = 0; m_fl[i] = 0; m_mw[i] = 0; m_wc[i] = 0;
            m_st[i] = 1'b0; m_to[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [4:0] c;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            c = ctrl_model(i == 1);
            if (c == 5'b11100 && m_mw[i] < 65535) m_mw[i]++;
            if (c == 5'b00011 && m_fl[i] < 65535) m_fl[i]++;
            if (c == 5'b10001 && m_hz[i] < 65535) m_hz[i]++;
            if (!m_st[i]) begin
                if (mem_req && !mem_ready) begin
                    m_st[i] = 1'b1;
                    m_wc[i] = 1;
                end
            end else if (!mem_req || mem_ready) begin
                m_st[i] = 1'b0;
                m_wc[i] = 0;
            end else begin
                m_wc[i]++;
                if (m_wc[i] >= 4) m_to[i] = 1'b1;
            end
        end
    endtask

    // Starts and ends at posedge+1 with inputs already applied.
    task automatic cycle();
        exp_t e;
        e.c0 = ctrl_model(1'b0);
        e.c1 = ctrl_model(1'b1);
        #1 sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        chk("ctl_nofwd", {ff0, fi0, fb0, fif0, fid0}, e.c0);
        chk("ctl_fwd",   {ff1, fi1, fb1, fif1, fid1}, e.c1);
        @(posedge clk);
        model_edge();
        #1;
        chk("hz_cnt0", hc0, m_hz[0]);
        chk("fl_cnt0", fc0, m_fl[0]);
        chk("mw_cnt0", mc0, m_mw[0]);
        chk("tmo0",    to0, m_to[0]);
        chk("hz_cnt1", hc1, m_hz[1]);
        chk("fl_cnt1", fc1, m_fl[1]);
        chk("mw_cnt1", mc1, m_mw[1]);
        chk("tmo1",    to1, m_to[1]);
    endtask

    task automatic clr();
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
        id_use_src1 = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_wb_en = 0; exe_branch = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic rnd();
        {id_src1, id_src2, exe_dest, mem_dest} = 16'($urandom);
        {id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en} = 5'($urandom);
        exe_branch = ($urandom_range(0, 3) == 0);
        mem_req    = $urandom_range(0, 1);
        mem_ready  = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rnd();
            cycle();
        end
        rst = 1'b0;
        clr();
        for (int i = 0; i < 3; i++) cycle();

        // RAW against EXE: stall without forwarding, none with it.
        exe_dest = 3; exe_wb_en = 1; id_src1 = 3; id_use_src1 = 1;
        cycle();
        chk("raw_exe_stall", {ff0, fi0, fb0, fif0, fid0}, 5'b10001);
        chk("raw_exe_hcnt", hc0, 1);
        chk("raw_exe_fwd_nostall", {ff1, fid1}, 2'b00);
        clr();
        mem_dest = 3; mem_wb_en = 1; id_src1 = 3; id_use_src1 = 1;
        cycle();
        chk("raw_mem_hcnt", hc0, 2);
        // src2 match only counts when id_two_src is set.
        clr();
        exe_dest = 9; exe_wb_en = 1; id_src2 = 9; id_src1 = 2; id_use_src1 = 1;
        cycle();
        id_two_src = 1;
        cycle();
        id_src2 = 8;
        cycle();

        // Load-use with forwarding: one bubble, then the load moves to MEM.
        clr();
        exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1; id_src2 = 5; id_two_src = 1;
        cycle();
        chk("loaduse_bubble", hc1, 1);
        exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 5; mem_wb_en = 1;
        cycle();
        chk("loaduse_once", hc1, 1);

        // Branch wins over an active hazard.
        clr();
        exe_dest = 7; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 7; id_use_src1 = 1;
        exe_branch = 1;
        snap = hc0;
        cycle();
        chk("br_flush_fc", fc0, 1);
        chk("br_hz_unchanged", hc0, snap);

        // Branch held through a 3-cycle memory wait; flushed on the ready cycle.
        clr();
        exe_branch = 1; mem_req = 1;
        snap = mc0;
        for (int i = 0; i < 3; i++) cycle();
        mem_ready = 1;
        cycle();
        chk("memwait_cnt3", mc0 - 16'(snap), 3);
        chk("br_after_wait_fc", fc0, 2);

        // Single-cycle access, then an abandoned request.
        clr();
        mem_req = 1; mem_ready = 1;
        cycle();
        mem_ready = 0;
        cycle();
        cycle();
        mem_req = 0;
        cycle();
        chk("abandon_no_tmo", to0, 0);

        // Watchdog: rises after the 4th wait cycle, freeze continues.
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("tmo_early", to0, 0);
        cycle();
        chk("tmo_rise", to0, 1);
        cycle();
        chk("tmo_sticky_freeze", {to0, ff0, fi0, fb0}, 4'b1111);

        // Asynchronous reset mid-wait.
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_ctl", {ff0, fi0, fb0, fif0, fid0, ff1, fi1, fb1, fif1, fid1}, 0);
        chk("arst_cnt", {to0, hc0, fc0, mc0}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clr();
        cycle();
        chk("post_rst_cnt", {to1, hc1, fc1, mc1}, 0);

        for (int i = 0; i < 200; i++) begin
            rnd();
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
